// File: rtl/btb_if.sv
// rtl/btb_if.sv - fetch lookup and EX-stage update bundle for the branch target buffer
interface btb_if;
  logic [31:0] pc;
  logic        btb_predicted;
  logic [31:0] btb_predicted_address;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  modport master (
    output pc, upd_en, upd_pc, upd_taken, upd_target, flush,
    input  btb_predicted, btb_predicted_address
  );

  modport slave (
    input  pc, upd_en, upd_pc, upd_taken, upd_target, flush,
    output btb_predicted, btb_predicted_address
  );
endinterface

// File: rtl/btb.sv
// rtl/btb.sv - direct-mapped branch target buffer with 2-bit saturating direction counters
// Combinational lookup on pc; EX-stage updates and flush are applied on the rising edge.
module btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic     Clk,
  input  logic     Reset,
  btb_if.slave     bus
);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic             do_alloc, do_train;
  logic [1:0]       u_ctr, u_ctr_nxt;
  logic             unused_lsbs;

  assign l_idx = bus.pc[IDX_W+1:2];
  assign l_tag = bus.pc[31:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[31:IDX_W+2];
  assign unused_lsbs = ^{bus.pc[1:0], bus.upd_pc[1:0]};

  // Valid gates everything, so unwritten tag/target/ctr storage never reaches the outputs.
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign bus.btb_predicted         = l_hit && ctr_q[l_idx][1];
  assign bus.btb_predicted_address = bus.btb_predicted ? target_q[l_idx] : 32'h0;

  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign do_train = bus.upd_en && !bus.flush && u_hit;
  assign do_alloc = bus.upd_en && !bus.flush && !u_hit && bus.upd_taken;
  assign u_ctr    = ctr_q[u_idx];

  always_comb begin
    u_ctr_nxt = u_ctr;
    if (bus.upd_taken) begin
      if (u_ctr != 2'b11) u_ctr_nxt = u_ctr + 2'd1;
    end else begin
      if (u_ctr != 2'b00) u_ctr_nxt = u_ctr - 2'd1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (bus.flush) valid_d = '0;
    else if (do_alloc) valid_d[u_idx] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload arrays are left unreset; a write racing reset lands in an entry that stays invalid.
  always_ff @(posedge Clk) begin
    if (do_alloc) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= bus.upd_target;
      ctr_q[u_idx]    <= 2'b10;
    end else if (do_train) begin
      ctr_q[u_idx] <= u_ctr_nxt;
      if (bus.upd_taken) target_q[u_idx] <= bus.upd_target;
    end
  end
endmodule

// File: tb/tb_btb.sv
// tb/tb_btb.sv - directed self-checking bench for btb
module tb_btb;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  btb_if bus ();

  btb #(.ENTRIES(16), .IDX_W(4)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_pred, input logic [31:0] exp_addr);
    bus.pc = pc;
    #1;
    check({tag, "_pred"}, {31'h0, bus.btb_predicted}, {31'h0, exp_pred});
    check({tag, "_addr"}, bus.btb_predicted_address, exp_addr);
  endtask

  task automatic upd(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
    bus.upd_en     = 1'b1;
    bus.upd_pc     = upc;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
    step();
    bus.upd_en     = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.pc = 32'h0;
    bus.upd_en = 1'b0;
    bus.upd_pc = 32'h0;
    bus.upd_taken = 1'b0;
    bus.upd_target = 32'h0;
    bus.flush = 1'b0;

    @(negedge clk);
    look("in_reset", 32'h40, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    look("after_reset", 32'h40, 1'b0, 32'h0);
    look("after_reset_0", 32'h0, 1'b0, 32'h0);

    // First update on the first edge after release, with a same-cycle lookup.
    bus.pc = 32'h40;
    bus.upd_en = 1'b1;
    bus.upd_pc = 32'h40;
    bus.upd_taken = 1'b1;
    bus.upd_target = 32'h100;
    #1;
    check("same_cycle_pred", {31'h0, bus.btb_predicted}, 32'h0);
    step();
    bus.upd_en = 1'b0;
    look("alloc", 32'h40, 1'b1, 32'h100);

    upd(32'h40, 1'b0, 32'h0);
    look("ctr01", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look("ctr00", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look("ctr00_sat", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h100);
    look("ctr01_up", 32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h100);
    look("ctr10_up", 32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h104);
    upd(32'h40, 1'b1, 32'h104);
    look("ctr11_newtgt", 32'h40, 1'b1, 32'h104);
    upd(32'h40, 1'b0, 32'hbad0);
    look("ctr11_sat_dn", 32'h40, 1'b1, 32'h104);

    // 0x80 shares index 0 with 0x40 but carries a different tag.
    upd(32'h80, 1'b1, 32'h200);
    look("alias_old", 32'h40, 1'b0, 32'h0);
    look("alias_new", 32'h80, 1'b1, 32'h200);
    look("alias_lsbs", 32'h83, 1'b1, 32'h200);

    upd(32'h44, 1'b0, 32'h444);
    look("miss_nt", 32'h44, 1'b0, 32'h0);
    upd(32'h1000_0004, 1'b1, 32'hdead_beec);
    look("idx1_hit", 32'h1000_0004, 1'b1, 32'hdead_beec);
    look("idx1_tagmiss", 32'h44, 1'b0, 32'h0);
    look("idx0_kept", 32'h80, 1'b1, 32'h200);

    bus.flush = 1'b1;
    upd(32'h48, 1'b1, 32'h300);
    bus.flush = 1'b0;
    look("flush_80", 32'h80, 1'b0, 32'h0);
    look("flush_1004", 32'h1000_0004, 1'b0, 32'h0);
    look("flush_drop", 32'h48, 1'b0, 32'h0);

    upd(32'h48, 1'b1, 32'h300);
    look("realloc", 32'h48, 1'b1, 32'h300);

    // Reset pulse lying entirely between two rising edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pred", {31'h0, bus.btb_predicted}, 32'h0);
    check("async_rst_addr", bus.btb_predicted_address, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    look("after_pulse", 32'h48, 1'b0, 32'h0);

    // Update presented while reset is held across the edge.
    rst_n = 1'b0;
    upd(32'h50, 1'b1, 32'h500);
    rst_n = 1'b1;
    look("rst_mid_upd", 32'h50, 1'b0, 32'h0);
    upd(32'h50, 1'b1, 32'h500);
    look("post_rst_alloc", 32'h50, 1'b1, 32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
